// File: rtl/pipe_pkg.sv
// Shared types and constants for the RV32I pipeline stages.
// ALU op codes, forwarding selects and branch funct3 values.
package pipe_pkg;

    localparam int XLEN_DEF = 32;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'b0000,
        ALU_SUB   = 4'b0001,
        ALU_AND   = 4'b0010,
        ALU_OR    = 4'b0011,
        ALU_XOR   = 4'b0100,
        ALU_SLT   = 4'b0101,
        ALU_SLTU  = 4'b0110,
        ALU_SLL   = 4'b0111,
        ALU_SRL   = 4'b1000,
        ALU_SRA   = 4'b1001,
        ALU_PASSB = 4'b1010
    } alu_op_t;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

endpackage

// File: rtl/alu.sv
// Combinational RV32I ALU; unlisted op codes produce zero.
module alu
    import pipe_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [XLEN-1:0] SrcA,
    input  logic [XLEN-1:0] SrcB,
    input  alu_op_t         ALUOp,
    output logic [XLEN-1:0] ALUResult
);

    // Operation select; shift amount is always the low five bits of SrcB.
    always_comb begin
        ALUResult = '0;
        case (ALUOp)
            ALU_ADD:   ALUResult = SrcA + SrcB;
            ALU_SUB:   ALUResult = SrcA - SrcB;
            ALU_AND:   ALUResult = SrcA & SrcB;
            ALU_OR:    ALUResult = SrcA | SrcB;
            ALU_XOR:   ALUResult = SrcA ^ SrcB;
            ALU_SLT:   ALUResult = {{(XLEN-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
            ALU_SLTU:  ALUResult = {{(XLEN-1){1'b0}}, (SrcA < SrcB)};
            ALU_SLL:   ALUResult = SrcA << SrcB[4:0];
            ALU_SRL:   ALUResult = SrcA >> SrcB[4:0];
            ALU_SRA:   ALUResult = $unsigned($signed(SrcA) >>> SrcB[4:0]);
            ALU_PASSB: ALUResult = SrcB;
            default:   ALUResult = '0;
        endcase
    end

endmodule

// File: rtl/execute_stage.sv
// RV32I execute stage: operand forwarding, ALU, branch/jump resolution
// and the EX/MEM pipeline register.
module execute_stage
    import pipe_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            RegWriteE,
    input  logic            MemWriteE,
    input  logic            JumpE,
    input  logic            BranchE,
    input  logic            JalrE,
    input  logic            ALUSrcE,
    input  logic [1:0]      ResultSrcE,
    input  logic [3:0]      ALUControlE,
    input  logic [2:0]      Funct3E,
    input  logic [4:0]      RdE,
    input  logic [XLEN-1:0] RD1E,
    input  logic [XLEN-1:0] RD2E,
    input  logic [XLEN-1:0] ImmExtE,
    input  logic [XLEN-1:0] PCE,
    input  logic [XLEN-1:0] PCPlus4E,
    input  logic [1:0]      ForwardAE,
    input  logic [1:0]      ForwardBE,
    input  logic [XLEN-1:0] ResultW,
    input  logic            FlushM,
    output logic            PCSrcE,
    output logic [XLEN-1:0] PCTargetE,
    output logic            RegWriteM,
    output logic            MemWriteM,
    output logic [1:0]      ResultSrcM,
    output logic [4:0]      RdM,
    output logic [XLEN-1:0] ALUResultM,
    output logic [XLEN-1:0] WriteDataM,
    output logic [XLEN-1:0] PCPlus4M
);

    logic [XLEN-1:0] SrcA;
    logic [XLEN-1:0] FwdB;
    logic [XLEN-1:0] SrcB;
    logic [XLEN-1:0] ALUResultE;
    logic [XLEN-1:0] jalrSum;
    logic            taken;

    function automatic logic [XLEN-1:0] fwdMux(
        input logic [1:0]      sel,
        input logic [XLEN-1:0] rf,
        input logic [XLEN-1:0] wb,
        input logic [XLEN-1:0] mem
    );
        case (fwd_sel_t'(sel))
            FWD_RF:  return rf;
            FWD_WB:  return wb;
            FWD_MEM: return mem;
            default: return rf;
        endcase
    endfunction

    // Forwarded operands; WriteDataM takes FwdB before the immediate mux.
    always_comb begin
        SrcA = fwdMux(ForwardAE, RD1E, ResultW, ALUResultM);
        FwdB = fwdMux(ForwardBE, RD2E, ResultW, ALUResultM);
        SrcB = ALUSrcE ? ImmExtE : FwdB;
    end

    alu #(.XLEN(XLEN)) u_alu (
        .SrcA      (SrcA),
        .SrcB      (SrcB),
        .ALUOp     (alu_op_t'(ALUControlE)),
        .ALUResult (ALUResultE)
    );

    // Branch condition compares SrcA with the forwarded rs2, never the immediate.
    always_comb begin
        taken = 1'b0;
        case (Funct3E)
            F3_BEQ:  taken = (SrcA == FwdB);
            F3_BNE:  taken = (SrcA != FwdB);
            F3_BLT:  taken = ($signed(SrcA) < $signed(FwdB));
            F3_BGE:  taken = ($signed(SrcA) >= $signed(FwdB));
            F3_BLTU: taken = (SrcA < FwdB);
            F3_BGEU: taken = (SrcA >= FwdB);
            default: taken = 1'b0;
        endcase
    end

    // Redirect decision and target go to fetch in the same cycle.
    always_comb begin
        jalrSum   = SrcA + ImmExtE;
        PCSrcE    = JumpE | (BranchE & taken);
        if (JalrE) begin
            PCTargetE = jalrSum & ~{{(XLEN-1){1'b0}}, 1'b1};
        end else begin
            PCTargetE = PCE + ImmExtE;
        end
    end

    // EX/MEM register: reset beats flush, flush inserts an all-zero bubble.
    always_ff @(posedge CLK) begin
        if (RESET || FlushM) begin
            RegWriteM  <= 1'b0;
            MemWriteM  <= 1'b0;
            ResultSrcM <= 2'b00;
            RdM        <= 5'd0;
            ALUResultM <= '0;
            WriteDataM <= '0;
            PCPlus4M   <= '0;
        end else begin
            RegWriteM  <= RegWriteE;
            MemWriteM  <= MemWriteE;
            ResultSrcM <= ResultSrcE;
            RdM        <= RdE;
            ALUResultM <= ALUResultE;
            WriteDataM <= FwdB;
            PCPlus4M   <= PCPlus4E;
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// Directed plus random checks of execute_stage against a behavioural model.
module tb_execute_stage;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        RegWriteE, MemWriteE, JumpE, BranchE, JalrE, ALUSrcE;
    logic [1:0]  ResultSrcE;
    logic [3:0]  ALUControlE;
    logic [2:0]  Funct3E;
    logic [4:0]  RdE;
    logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
    logic [1:0]  ForwardAE, ForwardBE;
    logic [31:0] ResultW;
    logic        FlushM;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        RegWriteM, MemWriteM;
    logic [1:0]  ResultSrcM;
    logic [4:0]  RdM;
    logic [31:0] ALUResultM, WriteDataM, PCPlus4M;

    int compared = 0;
    int mismatched = 0;

    // model of the EX/MEM register contents
    logic        mRegWrite = 1'b0, mMemWrite = 1'b0;
    logic [1:0]  mResultSrc = 2'b00;
    logic [4:0]  mRd = 5'd0;
    logic [31:0] mALU = 32'd0, mWD = 32'd0, mPC4 = 32'd0;

    execute_stage #(.XLEN(32)) dut (
        .CLK(CLK), .RESET(RESET),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE),
        .BranchE(BranchE), .JalrE(JalrE), .ALUSrcE(ALUSrcE),
        .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE), .Funct3E(Funct3E),
        .RdE(RdE), .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE),
        .PCPlus4E(PCPlus4E), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .ResultW(ResultW), .FlushM(FlushM), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
        .RdM(RdM), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] rf);
        if (sel == 2'd1) return ResultW;
        if (sel == 2'd2) return mALU;
        return rf;
    endfunction

    // signed ordering by flipping the sign bit, then unsigned compare
    function automatic logic sLess(input logic [31:0] a, input logic [31:0] b);
        return (a ^ 32'h8000_0000) < (b ^ 32'h8000_0000);
    endfunction

    function automatic logic [31:0] refAlu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int sh;
        sh = int'(b % 32'd32);
        case (op)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return sLess(a, b) ? 32'd1 : 32'd0;
            4'd6:  return (a < b) ? 32'd1 : 32'd0;
            4'd7:  return a << sh;
            4'd8:  return a >> sh;
            4'd9:  return (a >> sh) | ((a >= 32'h8000_0000) ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
            4'd10: return b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic refTaken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'b000: return a == b;
            3'b001: return a != b;
            3'b100: return sLess(a, b);
            3'b101: return !sLess(a, b);
            3'b110: return a < b;
            3'b111: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    task automatic clearInputs();
        RESET = 1'b0; FlushM = 1'b0;
        RegWriteE = 1'b0; MemWriteE = 1'b0; JumpE = 1'b0; BranchE = 1'b0;
        JalrE = 1'b0; ALUSrcE = 1'b0; ResultSrcE = 2'b00; ALUControlE = 4'd0;
        Funct3E = 3'b010; RdE = 5'd0; RD1E = 32'd0; RD2E = 32'd0; ImmExtE = 32'd0;
        PCE = 32'd0; PCPlus4E = 32'd0; ForwardAE = 2'b00; ForwardBE = 2'b00; ResultW = 32'd0;
    endtask

    // check redirect, clock once, update model and check the M outputs
    task automatic step();
        logic [31:0] a, fb, b, tgt;
        logic        bubble;
        #1;
        a  = pick(ForwardAE, RD1E);
        fb = pick(ForwardBE, RD2E);
        b  = ALUSrcE ? ImmExtE : fb;
        tgt = JalrE ? ((a + ImmExtE) & 32'hFFFF_FFFE) : (PCE + ImmExtE);
        check("PCSrcE", {31'd0, PCSrcE}, {31'd0, JumpE | (BranchE & refTaken(Funct3E, a, fb))});
        check("PCTargetE", PCTargetE, tgt);
        bubble = RESET | FlushM;
        @(posedge CLK);
        #1;
        mRegWrite  = bubble ? 1'b0 : RegWriteE;
        mMemWrite  = bubble ? 1'b0 : MemWriteE;
        mResultSrc = bubble ? 2'b00 : ResultSrcE;
        mRd        = bubble ? 5'd0 : RdE;
        mALU       = bubble ? 32'd0 : refAlu(ALUControlE, a, b);
        mWD        = bubble ? 32'd0 : fb;
        mPC4       = bubble ? 32'd0 : PCPlus4E;
        check("RegWriteM", {31'd0, RegWriteM}, {31'd0, mRegWrite});
        check("MemWriteM", {31'd0, MemWriteM}, {31'd0, mMemWrite});
        check("ResultSrcM", {30'd0, ResultSrcM}, {30'd0, mResultSrc});
        check("RdM", {27'd0, RdM}, {27'd0, mRd});
        check("ALUResultM", ALUResultM, mALU);
        check("WriteDataM", WriteDataM, mWD);
        check("PCPlus4M", PCPlus4M, mPC4);
    endtask

    initial begin
        // reset for two cycles with busy inputs
        clearInputs();
        RESET = 1'b1; RegWriteE = 1'b1; MemWriteE = 1'b1; ResultSrcE = 2'b10; RdE = 5'd9;
        RD1E = 32'hDEAD_BEEF; RD2E = 32'h1234_5678; PCPlus4E = 32'h44; FlushM = 1'b0;
        step(); step();
        check("reset_alu", ALUResultM, 32'd0);

        clearInputs(); RD1E = 32'd5; RD2E = 32'd7; RegWriteE = 1'b1; RdE = 5'd3;
        step();
        check("add_5_7", ALUResultM, 32'd12);

        clearInputs(); ForwardAE = 2'b10; RD2E = 32'd1; ALUControlE = 4'd1;
        step();
        check("fwd_mem_sub", ALUResultM, 32'd11);

        clearInputs(); RD1E = 32'd20; ForwardBE = 2'b01; ResultW = 32'hFF;
        MemWriteE = 1'b1; ALUSrcE = 1'b1; ImmExtE = 32'd4;
        step();
        check("fwd_wb_store", WriteDataM, 32'hFF);
        check("store_addr", ALUResultM, 32'd24);

        clearInputs(); BranchE = 1'b1; Funct3E = 3'b100; RD1E = 32'hFFFF_FFFF; RD2E = 32'd1;
        PCE = 32'h100; ImmExtE = 32'hFFFF_FFF0;
        #1; check("blt_taken", {31'd0, PCSrcE}, 32'd1);
        check("branch_target", PCTargetE, 32'hF0);
        step();
        Funct3E = 3'b110;
        #1; check("bltu_not_taken", {31'd0, PCSrcE}, 32'd0);
        step();

        clearInputs(); JalrE = 1'b1; JumpE = 1'b1; RD1E = 32'h203; PCPlus4E = 32'h108;
        RegWriteE = 1'b1; ResultSrcE = 2'b10; RdE = 5'd1;
        #1; check("jalr_target", PCTargetE, 32'h202);
        step();
        check("jalr_pc4", PCPlus4M, 32'h108);

        clearInputs(); RD1E = 32'h8000_0000; ALUSrcE = 1'b1; ImmExtE = 32'd4; ALUControlE = 4'd9;
        step(); check("sra", ALUResultM, 32'hF800_0000);
        ALUControlE = 4'd8;
        step(); check("srl", ALUResultM, 32'h0800_0000);
        ALUControlE = 4'd10; ImmExtE = 32'h1234_5000;
        step(); check("lui", ALUResultM, 32'h1234_5000);
        ALUControlE = 4'd0; RD1E = 32'hFFFF_FFFF; ImmExtE = 32'd1;
        step(); check("add_wrap", ALUResultM, 32'd0);

        clearInputs(); FlushM = 1'b1; RegWriteE = 1'b1; MemWriteE = 1'b1; RdE = 5'd7; RD1E = 32'd3;
        step();
        clearInputs(); RESET = 1'b1; FlushM = 1'b1; RegWriteE = 1'b1; RdE = 5'd8; RD1E = 32'd3;
        step();
        clearInputs(); RegWriteE = 1'b1; RdE = 5'd10; RD1E = 32'd77;
        step();
        RESET = 1'b1;
        step();
        check("midstream_reset_rd", {27'd0, RdM}, 32'd0);

        for (int i = 0; i < 300; i++) begin
            RESET       = ($urandom_range(15) == 0);
            FlushM      = ($urandom_range(7) == 0);
            RegWriteE   = 1'($urandom_range(1));
            MemWriteE   = 1'($urandom_range(1));
            JumpE       = 1'($urandom_range(1));
            BranchE     = 1'($urandom_range(1));
            JalrE       = 1'($urandom_range(1));
            ALUSrcE     = 1'($urandom_range(1));
            ResultSrcE  = 2'($urandom_range(3));
            ALUControlE = 4'($urandom_range(15));
            Funct3E     = 3'($urandom_range(7));
            RdE         = 5'($urandom_range(31));
            RD1E        = ($urandom_range(3) == 0) ? RD2E : $urandom;
            RD2E        = $urandom;
            ImmExtE     = $urandom;
            PCE         = $urandom;
            PCPlus4E    = PCE + 32'd4;
            ForwardAE   = 2'($urandom_range(3));
            ForwardBE   = 2'($urandom_range(3));
            ResultW     = $urandom;
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
